// File: rtl/rf_write_port_ctrl.sv
// ---------------------------------------------------------------------------
// rf_write_port_ctrl
//
// Owns the register file write port. Each cycle it chooses one result to
// write:
//   - the pipeline writeback, which always takes the port and has no ready, or
//   - the head of a small FIFO that buffers results from the mul/div unit (MDU).
// A scoreboard holds one "pending MDU write" bit per register. Decode uses it
// to stall on RAW hazards against MDU results that are still in flight.
// Writes to r0 are suppressed here, because the register file does not
// protect r0 itself.
//
// Ports
//   clk, rst                        clock; asynchronous active-high reset
//   wb_valid/wb_addr/wb_data        pipeline writeback (always accepted)
//   mdu_valid/mdu_addr/mdu_data     MDU result; transfers on mdu_valid && mdu_ready
//   mdu_ready                       FIFO not full
//   issue_valid/issue_addr          MDU op issued; marks its destination pending
//   query_addr_1/2                  decode source registers
//   query_pending_1/2               the queried register awaits an MDU write
//   RFWr/RF_address_write/RF_data_write  registered register-file write port
// ---------------------------------------------------------------------------
module rf_write_port_ctrl #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              mdu_valid,
    input  logic [ADDR_W-1:0] mdu_addr,
    input  logic [DATA_W-1:0] mdu_data,
    output logic              mdu_ready,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [ADDR_W-1:0] query_addr_1,
    input  logic [ADDR_W-1:0] query_addr_2,
    output logic              query_pending_1,
    output logic              query_pending_2,
    output logic              RFWr,
    output logic [ADDR_W-1:0] RF_address_write,
    output logic [DATA_W-1:0] RF_data_write
);

    localparam int              PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int              NUM_REGS  = 1 << ADDR_W;
    localparam logic [PTR_W:0]  DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    // -----------------------------------------------------------------------
    // MDU result FIFO
    // -----------------------------------------------------------------------
    logic [ADDR_W-1:0] fifo_addr_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W:0]    count_reg;

    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    assign fifo_full  = (count_reg == DEPTH_CNT);
    assign fifo_empty = (count_reg == '0);

    // Ready depends only on the current occupancy. A pop in the same cycle
    // does not free a slot early, so no combinational path runs from
    // wb_valid to mdu_ready.
    assign mdu_ready = !fifo_full;
    assign push      = mdu_valid && !fifo_full;
    // The writeback owns the port. The FIFO drains only in idle cycles.
    assign pop       = !wb_valid && !fifo_empty;

    assign head_addr = fifo_addr_mem[rd_ptr_reg];
    assign head_data = fifo_data_mem[rd_ptr_reg];

    // The storage has no reset. Clearing the pointers is enough to discard
    // any buffered entries.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_mem[wr_ptr_reg] <= mdu_addr;
            fifo_data_mem[wr_ptr_reg] <= mdu_data;
        end
    end

    // FIFO_DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Write port arbitration and output register
    // -----------------------------------------------------------------------
    logic              sel_valid;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    always_comb begin
        sel_valid = 1'b0;
        sel_addr  = head_addr;
        sel_data  = head_data;
        if (wb_valid) begin
            sel_valid = 1'b1;
            sel_addr  = wb_addr;
            sel_data  = wb_data;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
        end
    end

    // An r0 result still passes through the address/data registers and is
    // popped, but the write enable stays low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RFWr             <= 1'b0;
            RF_address_write <= '0;
            RF_data_write    <= '0;
        end else if (sel_valid) begin
            RFWr             <= (sel_addr != '0);
            RF_address_write <= sel_addr;
            RF_data_write    <= sel_data;
        end else begin
            RFWr             <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Pending-write scoreboard
    // -----------------------------------------------------------------------
    logic [NUM_REGS-1:0] pending_reg;
    logic [NUM_REGS-1:0] pending_next;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pending
            if (gi == 0) begin : g_r0
                // r0 never becomes pending.
                assign pending_next[gi] = 1'b0;
            end else begin : g_rn
                logic set_hit;
                logic clr_hit;
                assign set_hit = issue_valid && (issue_addr == ADDR_W'(gi));
                assign clr_hit = pop && (head_addr == ADDR_W'(gi));
                // A reissue in the same cycle as the emit of the older op
                // must leave the bit set, because the new op is still
                // outstanding.
                assign pending_next[gi] = set_hit ? 1'b1 :
                                          clr_hit ? 1'b0 : pending_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    assign query_pending_1 = pending_reg[query_addr_1];
    assign query_pending_2 = pending_reg[query_addr_2];

endmodule

// File: tb/tb_rf_write_port_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rf_write_port_ctrl
//
// Directed bench for rf_write_port_ctrl. Inputs are driven 1 time unit after
// each posedge, and outputs are sampled at the same point. A small register
// file model captures writes on the negedge, the same way the real register
// file does.
// ---------------------------------------------------------------------------
module tb_rf_write_port_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              mdu_valid;
    logic [ADDR_W-1:0] mdu_addr;
    logic [DATA_W-1:0] mdu_data;
    logic              mdu_ready;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_addr;
    logic [ADDR_W-1:0] query_addr_1;
    logic [ADDR_W-1:0] query_addr_2;
    logic              query_pending_1;
    logic              query_pending_2;
    logic              RFWr;
    logic [ADDR_W-1:0] RF_address_write;
    logic [DATA_W-1:0] RF_data_write;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W-1:0] rf_model [1 << ADDR_W];

    always #5 clk = ~clk;

    rf_write_port_ctrl #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .wb_valid         (wb_valid),
        .wb_addr          (wb_addr),
        .wb_data          (wb_data),
        .mdu_valid        (mdu_valid),
        .mdu_addr         (mdu_addr),
        .mdu_data         (mdu_data),
        .mdu_ready        (mdu_ready),
        .issue_valid      (issue_valid),
        .issue_addr       (issue_addr),
        .query_addr_1     (query_addr_1),
        .query_addr_2     (query_addr_2),
        .query_pending_1  (query_pending_1),
        .query_pending_2  (query_pending_2),
        .RFWr             (RFWr),
        .RF_address_write (RF_address_write),
        .RF_data_write    (RF_data_write)
    );

    // The register file samples the write port on the negedge.
    always @(negedge clk) begin
        if (RFWr) begin
            rf_model[RF_address_write] <= RF_data_write;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid    = 1'b0;
        wb_addr     = '0;
        wb_data     = '0;
        mdu_valid   = 1'b0;
        mdu_addr    = '0;
        mdu_data    = '0;
        issue_valid = 1'b0;
        issue_addr  = '0;
    endtask

    initial begin
        rst          = 1'b1;
        query_addr_1 = '0;
        query_addr_2 = '0;
        idle_inputs();
        for (int i = 0; i < (1 << ADDR_W); i++) rf_model[i] = '0;
        step();
        step();
        check("rst_rfwr",  {31'd0, RFWr}, 32'd0);
        check("rst_addr",  {27'd0, RF_address_write}, 32'd0);
        check("rst_data",  RF_data_write, 32'd0);
        check("rst_ready", {31'd0, mdu_ready}, 32'd1);
        rst = 1'b0;
        step();

        // ---- wb-only write to r5 ----
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        step();
        check("wb_rfwr", {31'd0, RFWr}, 32'd1);
        check("wb_addr", {27'd0, RF_address_write}, 32'd5);
        check("wb_data", RF_data_write, 32'hDEADBEEF);
        idle_inputs();
        @(negedge clk);
        #1;
        check("wb_rf_r5", rf_model[5], 32'hDEADBEEF);
        step();
        check("idle_rfwr",      {31'd0, RFWr}, 32'd0);
        check("idle_addr_hold", {27'd0, RF_address_write}, 32'd5);
        check("idle_data_hold", RF_data_write, 32'hDEADBEEF);

        // ---- collision: wb(3) and mdu(7) in the same cycle ----
        query_addr_1 = 5'd7;
        issue_valid = 1'b1; issue_addr = 5'd7;
        step();
        idle_inputs();
        check("col_pend7_set", {31'd0, query_pending_1}, 32'd1);
        wb_valid  = 1'b1; wb_addr  = 5'd3; wb_data  = 32'h11;
        mdu_valid = 1'b1; mdu_addr = 5'd7; mdu_data = 32'h22;
        step();
        idle_inputs();
        check("col_c1_rfwr", {31'd0, RFWr}, 32'd1);
        check("col_c1_addr", {27'd0, RF_address_write}, 32'd3);
        check("col_c1_data", RF_data_write, 32'h11);
        check("col_c1_pend7", {31'd0, query_pending_1}, 32'd1);
        step();
        check("col_c2_rfwr", {31'd0, RFWr}, 32'd1);
        check("col_c2_addr", {27'd0, RF_address_write}, 32'd7);
        check("col_c2_data", RF_data_write, 32'h22);
        check("col_c2_pend7", {31'd0, query_pending_1}, 32'd0);

        // ---- fill the FIFO while wb holds the port ----
        wb_valid  = 1'b1; wb_addr  = 5'd1;  wb_data  = 32'hA1;
        mdu_valid = 1'b1; mdu_addr = 5'd10; mdu_data = 32'h100;
        step();
        check("full_ready_1", {31'd0, mdu_ready}, 32'd1);
        mdu_addr = 5'd11; mdu_data = 32'h200;
        step();
        check("full_ready_0", {31'd0, mdu_ready}, 32'd0);
        mdu_addr = 5'd12; mdu_data = 32'h300;
        step();
        check("full_held_ready", {31'd0, mdu_ready}, 32'd0);
        check("full_wb_addr", {27'd0, RF_address_write}, 32'd1);
        idle_inputs();
        step();
        check("drain1_addr",  {27'd0, RF_address_write}, 32'd10);
        check("drain1_data",  RF_data_write, 32'h100);
        check("drain1_ready", {31'd0, mdu_ready}, 32'd1);
        step();
        check("drain2_addr", {27'd0, RF_address_write}, 32'd11);
        check("drain2_data", RF_data_write, 32'h200);
        check("drain2_rfwr", {31'd0, RFWr}, 32'd1);
        // The third result was held off, so the MDU presents it again now.
        mdu_valid = 1'b1; mdu_addr = 5'd12; mdu_data = 32'h300;
        step();
        idle_inputs();
        check("drain_empty_rfwr", {31'd0, RFWr}, 32'd0);
        step();
        check("third_addr", {27'd0, RF_address_write}, 32'd12);
        check("third_data", RF_data_write, 32'h300);

        // ---- r0 guard ----
        query_addr_1 = 5'd0;
        mdu_valid   = 1'b1; mdu_addr = 5'd0; mdu_data = 32'h55;
        issue_valid = 1'b1; issue_addr = 5'd0;
        step();
        idle_inputs();
        check("r0_pend",       {31'd0, query_pending_1}, 32'd0);
        check("r0_push_rfwr",  {31'd0, RFWr}, 32'd0);
        step();
        check("r0_pop_rfwr",   {31'd0, RFWr}, 32'd0);
        check("r0_pop_ready",  {31'd0, mdu_ready}, 32'd1);
        mdu_valid = 1'b1; mdu_addr = 5'd4; mdu_data = 32'h44;
        step();
        idle_inputs();
        step();
        check("r0_next_rfwr", {31'd0, RFWr}, 32'd1);
        check("r0_next_addr", {27'd0, RF_address_write}, 32'd4);

        // ---- scoreboard: emit and reissue of r9 in the same cycle ----
        query_addr_1 = 5'd9;
        query_addr_2 = 5'd4;
        issue_valid = 1'b1; issue_addr = 5'd9;
        step();
        idle_inputs();
        check("sb_set9", {31'd0, query_pending_1}, 32'd1);
        check("sb_q2_r4", {31'd0, query_pending_2}, 32'd0);
        mdu_valid = 1'b1; mdu_addr = 5'd9; mdu_data = 32'hA9;
        step();
        idle_inputs();
        check("sb_in_fifo9", {31'd0, query_pending_1}, 32'd1);
        issue_valid = 1'b1; issue_addr = 5'd9;
        step();
        idle_inputs();
        check("sb_emit1_addr", {27'd0, RF_address_write}, 32'd9);
        check("sb_emit1_pend", {31'd0, query_pending_1}, 32'd1);
        step();
        check("sb_wait_pend", {31'd0, query_pending_1}, 32'd1);
        mdu_valid = 1'b1; mdu_addr = 5'd9; mdu_data = 32'hB9;
        step();
        idle_inputs();
        check("sb_in_fifo9b", {31'd0, query_pending_1}, 32'd1);
        step();
        check("sb_emit2_data", RF_data_write, 32'hB9);
        check("sb_emit2_pend", {31'd0, query_pending_1}, 32'd0);

        // ---- reset mid-operation ----
        query_addr_1 = 5'd6;
        wb_valid    = 1'b1; wb_addr  = 5'd2; wb_data  = 32'h2222;
        mdu_valid   = 1'b1; mdu_addr = 5'd6; mdu_data = 32'h66;
        issue_valid = 1'b1; issue_addr = 5'd6;
        step();
        check("pre_rst_pend6", {31'd0, query_pending_1}, 32'd1);
        check("pre_rst_rfwr",  {31'd0, RFWr}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_rfwr",  {31'd0, RFWr}, 32'd0);
        check("mid_rst_addr",  {27'd0, RF_address_write}, 32'd0);
        check("mid_rst_data",  RF_data_write, 32'd0);
        check("mid_rst_ready", {31'd0, mdu_ready}, 32'd1);
        for (int a = 0; a < (1 << ADDR_W); a++) begin
            query_addr_1 = ADDR_W'(a);
            #0.1;
            if (query_pending_1 !== 1'b0) begin
                check($sformatf("mid_rst_pend_r%0d", a), {31'd0, query_pending_1}, 32'd0);
            end
        end
        check("mid_rst_pend_r6", {31'd0, dut.pending_reg[6]}, 32'd0);
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        step();
        check("post_rst_no_pop", {31'd0, RFWr}, 32'd0);
        step();
        check("post_rst_still_idle", {31'd0, RFWr}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
